// File: rtl/arb_pkg.sv
// Shared types and helpers for the request arbiter.
package arb_pkg;

  localparam int unsigned MaxReq = 16;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_e;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_e;

  // OR-reduce set positions; exact for one-hot, 0 for all-zero.
  function automatic logic [3:0] onehot_to_idx(input logic [MaxReq-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MaxReq; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational masked priority picker: first set bit at or above i_ptr, wrapping.
module prio_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_win,
  output logic          o_any
);

  logic [N-1:0] w_eff;
  logic [N-1:0] w_rot;
  logic [N-1:0] w_rot_oh;

  assign w_eff    = i_req & ~i_mask;
  // Rotate right so the pointer position becomes bit 0, isolate lowest set bit, rotate back.
  assign w_rot    = N'({w_eff, w_eff} >> i_ptr);
  assign w_rot_oh = w_rot & (~w_rot + {{(N-1){1'b0}}, 1'b1});
  assign o_win    = N'({w_rot_oh, w_rot_oh} >> (N - 32'(i_ptr)));
  assign o_any    = |w_eff;

endmodule

// File: rtl/prio_arbiter.sv
// N-way arbiter with registered one-hot grant, fixed or round-robin selection,
// grant locking and an optional hold timeout.
module prio_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter arb_mode_e   MODE     = ARB_FIXED,
  parameter int unsigned MAX_HOLD = 0,
  parameter int unsigned IW       = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic          o_gnt_valid,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_timeout
);

  localparam int unsigned HW       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam int unsigned HoldLast = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  arb_state_e    r_state;
  logic [N-1:0]  r_gnt;
  logic          r_gnt_valid;
  logic [IW-1:0] r_gnt_idx;
  logic [IW-1:0] r_ptr;
  logic [HW-1:0] r_hold;
  logic          r_timeout;

  logic          w_owner_req;
  logic          w_limit;
  logic          w_force;
  logic          w_grant;
  logic [N-1:0]  w_mask;
  logic [IW-1:0] w_ptr;
  logic [N-1:0]  w_win;
  logic          w_any;
  logic [IW-1:0] w_win_idx;
  logic [IW-1:0] w_next_ptr;

  assign w_owner_req = |(i_req & r_gnt);
  assign w_limit     = (MAX_HOLD != 0) && (r_hold == HW'(HoldLast));
  // An owner drop at the threshold is a plain handover, so force needs the owner still asking.
  assign w_force     = (r_state == BUSY) && w_owner_req && w_limit;
  assign w_mask      = w_force ? r_gnt : '0;
  assign w_ptr       = (MODE == ARB_RR) ? r_ptr : '0;

  prio_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_req  (i_req),
    .i_mask (w_mask),
    .i_ptr  (w_ptr),
    .o_win  (w_win),
    .o_any  (w_any)
  );

  assign w_win_idx  = IW'(onehot_to_idx(16'(w_win)));
  assign w_next_ptr = (w_win_idx == IW'(N - 1)) ? '0 : w_win_idx + IW'(1);
  assign w_grant    = w_any && ((r_state == IDLE) || !w_owner_req || w_limit);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
      r_ptr       <= '0;
      r_hold      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (w_grant) begin
        r_state     <= BUSY;
        r_gnt       <= w_win;
        r_gnt_valid <= 1'b1;
        r_gnt_idx   <= w_win_idx;
        r_ptr       <= w_next_ptr;
        r_hold      <= '0;
        r_timeout   <= w_force;
      end else if (r_state == BUSY) begin
        if (!w_owner_req) begin
          r_state     <= IDLE;
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
          r_gnt_idx   <= '0;
          r_hold      <= '0;
        end else if (w_limit) begin
          // Sole requester at the limit keeps the resource and starts a fresh hold window.
          r_hold <= '0;
        end else begin
          r_hold <= r_hold + HW'(1);
        end
      end
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_idx   = r_gnt_idx;
  assign o_timeout   = r_timeout;

  a_gnt_onehot : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    $onehot0(o_gnt) && (o_gnt_valid == (|o_gnt)) &&
    (o_gnt_idx == IW'(onehot_to_idx(16'(o_gnt)))));

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: fixed, round-robin and timeout instances checked via a scoreboard.
module tb_prio_arbiter;
  import arb_pkg::*;

  typedef struct packed {
    logic [3:0] gnt;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_fx, req_rr, req_to;
  logic [3:0] gnt_fx, gnt_rr, gnt_to;
  logic       v_fx, v_rr, v_to;
  logic [1:0] idx_fx, idx_rr, idx_to;
  logic       to_fx, to_rr, to_to;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  prio_arbiter #(.N(4), .MODE(ARB_FIXED), .MAX_HOLD(0)) u_fx (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_fx), .o_gnt(gnt_fx),
    .o_gnt_valid(v_fx), .o_gnt_idx(idx_fx), .o_timeout(to_fx)
  );

  prio_arbiter #(.N(4), .MODE(ARB_RR), .MAX_HOLD(0)) u_rr (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_rr), .o_gnt(gnt_rr),
    .o_gnt_valid(v_rr), .o_gnt_idx(idx_rr), .o_timeout(to_rr)
  );

  prio_arbiter #(.N(4), .MODE(ARB_FIXED), .MAX_HOLD(4)) u_to (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_to), .o_gnt(gnt_to),
    .o_gnt_valid(v_to), .o_gnt_idx(idx_to), .o_timeout(to_to)
  );

  function automatic logic [1:0] exp_idx(input logic [3:0] g);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    req_fx = '0;
    req_rr = '0;
    req_to = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    req_fx = 4'b1111;
    req_rr = 4'b1111;
    req_to = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{gnt: 4'b0000, to: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({gnt_fx, v_fx, idx_fx, to_fx} !== {e.gnt, |e.gnt, exp_idx(e.gnt), e.to}) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: gnt=%b valid=%b idx=%0d to=%b, need gnt=%b",
                 i, gnt_fx, v_fx, idx_fx, to_fx, e.gnt);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{gnt: 4'b0001, to: 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({gnt_fx, v_fx, idx_fx, to_fx} !== {e.gnt, |e.gnt, exp_idx(e.gnt), e.to}) begin
      errors++;
      $display("FAIL reset_release: gnt=%b valid=%b idx=%0d to=%b, need gnt=%b idx=%0d",
               gnt_fx, v_fx, idx_fx, to_fx, e.gnt, exp_idx(e.gnt));
    end
    checks++;
    if ({gnt_rr, idx_rr} !== {e.gnt, exp_idx(e.gnt)}) begin
      errors++;
      $display("FAIL reset_release_rr: gnt=%b idx=%0d, need gnt=%b", gnt_rr, idx_rr, e.gnt);
    end
  endtask

  task automatic test_fixed();
    logic [3:0] rq[9];
    logic [3:0] eg[9];
    exp_t       e;
    rq = '{4'b1010, 4'b1010, 4'b1000, 4'b0000, 4'b0101, 4'b0101, 4'b0100, 4'b0110, 4'b0000};
    eg = '{4'b0010, 4'b0010, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      req_fx = rq[i];
      sb.push_back('{gnt: eg[i], to: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({gnt_fx, v_fx, idx_fx, to_fx} !== {e.gnt, |e.gnt, exp_idx(e.gnt), e.to}) begin
        errors++;
        $display("FAIL fixed step %0d: gnt=%b valid=%b idx=%0d to=%b, need gnt=%b idx=%0d",
                 i, gnt_fx, v_fx, idx_fx, to_fx, e.gnt, exp_idx(e.gnt));
      end
    end
  endtask

  task automatic test_rr_rotation();
    logic [3:0] rq[6];
    logic [3:0] eg[6];
    exp_t       e;
    do_reset();
    rq = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000};
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      req_rr = rq[i];
      sb.push_back('{gnt: eg[i], to: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({gnt_rr, v_rr, idx_rr, to_rr} !== {e.gnt, |e.gnt, exp_idx(e.gnt), e.to}) begin
        errors++;
        $display("FAIL rr step %0d: gnt=%b valid=%b idx=%0d to=%b, need gnt=%b idx=%0d",
                 i, gnt_rr, v_rr, idx_rr, to_rr, e.gnt, exp_idx(e.gnt));
      end
    end
  endtask

  task automatic test_mid_grant_reset();
    logic [3:0] rq[3];
    logic [3:0] eg[3];
    exp_t       e;
    do_reset();
    rq = '{4'b1111, 4'b1110, 4'b1100};
    eg = '{4'b0001, 4'b0010, 4'b0100};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_rr = rq[i];
      sb.push_back('{gnt: eg[i], to: 1'b0});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({gnt_rr, v_rr, idx_rr} !== {e.gnt, |e.gnt, exp_idx(e.gnt)}) begin
        errors++;
        $display("FAIL midrst_setup step %0d: gnt=%b idx=%0d, need gnt=%b",
                 i, gnt_rr, idx_rr, e.gnt);
      end
    end
    // Owner is 2 with pointer at 3; reset must clear outputs without a clock edge.
    @(negedge clk);
    rst_n = 1'b0;
    sb.push_back('{gnt: 4'b0000, to: 1'b0});
    #1;
    e = sb.pop_front();
    checks++;
    if ({gnt_rr, v_rr, idx_rr, to_rr} !== {e.gnt, |e.gnt, exp_idx(e.gnt), e.to}) begin
      errors++;
      $display("FAIL midrst_async: gnt=%b valid=%b idx=%0d to=%b, need all zero",
               gnt_rr, v_rr, idx_rr, to_rr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back('{gnt: 4'b0100, to: 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({gnt_rr, v_rr, idx_rr, to_rr} !== {e.gnt, |e.gnt, exp_idx(e.gnt), e.to}) begin
      errors++;
      $display("FAIL midrst_ptr: gnt=%b idx=%0d, need gnt=%b idx=%0d",
               gnt_rr, idx_rr, e.gnt, exp_idx(e.gnt));
    end
  endtask

  task automatic run_to(input string name, input int n, input logic [3:0] rq[12],
                        input logic [3:0] eg[12], input logic et[12]);
    exp_t e;
    do_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req_to = rq[i];
      sb.push_back('{gnt: eg[i], to: et[i]});
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if ({gnt_to, v_to, idx_to, to_to} !== {e.gnt, |e.gnt, exp_idx(e.gnt), e.to}) begin
        errors++;
        $display("FAIL %s step %0d: gnt=%b valid=%b idx=%0d to=%b, need gnt=%b to=%b",
                 name, i, gnt_to, v_to, idx_to, to_to, e.gnt, e.to);
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] rq[12];
    logic [3:0] eg[12];
    logic       et[12];
    rq = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
           4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
    eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010,
           4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    run_to("timeout", 12, rq, eg, et);
  endtask

  task automatic test_timeout_single();
    logic [3:0] rq[12];
    logic [3:0] eg[12];
    logic       et[12];
    for (int i = 0; i < 12; i++) begin
      rq[i] = (i < 11) ? 4'b0001 : 4'b0000;
      eg[i] = (i < 11) ? 4'b0001 : 4'b0000;
      et[i] = 1'b0;
    end
    run_to("timeout_single", 12, rq, eg, et);
  endtask

  task automatic test_drop_at_threshold();
    logic [3:0] rq[12];
    logic [3:0] eg[12];
    logic       et[12];
    for (int i = 0; i < 12; i++) begin
      rq[i] = 4'b0000;
      eg[i] = 4'b0000;
      et[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      rq[i] = 4'b0011;
      eg[i] = 4'b0001;
    end
    rq[4] = 4'b0010;
    eg[4] = 4'b0010;
    rq[5] = 4'b1010;
    eg[5] = 4'b0010;
    run_to("drop_threshold", 7, rq, eg, et);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fixed();
    test_rr_rotation();
    test_mid_grant_reset();
    test_timeout();
    test_timeout_single();
    test_drop_at_threshold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Parametrised N-way request arbiter with registered one-hot grant, selectable fixed-priority or round-robin mode, grant locking, and a hold-timeout that forces re-arbitration. It generalises the team's single-winner priority-if selection into a clocked, reusable block that sits in front of any shared resource (bus port, memory bank, shared FIFO write side). Exactly one requester owns the resource at a time. Ownership changes only at the clock edges defined below.

## Interface
- `N`, 4: number of requesters, 2..16.
- `MODE`, `ARB_FIXED`: `arb_mode_e`, either `ARB_FIXED` (index 0 highest) or `ARB_RR` (round-robin).
- `MAX_HOLD`, 0: maximum consecutive grant cycles before forced re-arbitration. 0 disables the timeout.
- `IW`, `$clog2(N)`: width of the index output. Derived; do not override.
- `clk`  in  1  clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  N  request vector, level-sensitive.
- `gnt`  out  N  registered one-hot grant, all-zero when idle.
- `gnt_valid`  out  1  high when `gnt` is non-zero.
- `gnt_idx`  out  IW  index of the granted requester, 0 when idle.
- `timeout`  out  1  single-cycle pulse in the cycle a forced re-arbitration takes effect.

## Operation
- States (`arb_state_e`): `IDLE`, `BUSY`.
- **Reset:**
  - `gnt`=0, `gnt_valid`=0, `gnt_idx`=0, `timeout`=0.
  - State=`IDLE`, RR pointer=0, hold counter=0.
- **`IDLE`:**
  - If `req` is non-zero, pick a winner and go to `BUSY`.
  - Otherwise stay in `IDLE`.
- **`BUSY` with owner still requesting:** when `req[owner]`=1 and the hold limit is not reached, hold the grant and increment the hold counter.
- **`BUSY` with owner dropped:** when `req[owner]`=0, re-arbitrate among the current `req` in the same cycle, so back-to-back handover takes zero idle cycles.
  - If no request remains, go to `IDLE` and clear `gnt`.
- **Timeout (`MAX_HOLD`>0):** triggers when the hold counter reaches `MAX_HOLD`-1 while the owner is still requesting.
  - If any other requester is active, re-arbitrate with the owner masked out and pulse `timeout`.
  - If only the owner is requesting, keep the grant, reset the counter, and do not pulse `timeout`.
- **Winner selection:**
  - Fixed mode: lowest set index wins.
  - RR mode: first set bit at or above the pointer wins, wrapping to index 0.
  - The pointer updates to (winner+1) mod N on every new grant. It never changes while a grant is held.
- **Hold counter:** resets to 0 on every new grant. Width is `$clog2(MAX_HOLD+1)`, minimum 1.
- **Uniqueness:** `gnt` is one-hot or zero at all times. An assertion checks `$onehot0(gnt)` and that `gnt_idx` matches `gnt`.

## Timing
- A grant appears one cycle after `req` is sampled. `req` rising at edge k gives `gnt` at edge k+1.
- Handover latency is 1 cycle from the owner's `req` drop to the next grant.
- `gnt_valid` and `gnt_idx` are registered with `gnt`. They carry no extra latency.
- Asynchronous reset mid-grant clears all outputs immediately. The first grant after release follows the same 1-cycle rule, with the pointer at 0.
- **Simultaneous events:**
  - Owner drop together with the timeout threshold is treated as a drop. No `timeout` pulse.
  - A requester that rises in the same cycle as a handover competes in that handover.
- `req` bits of non-owners may toggle freely. They are only evaluated at arbitration points.

## Structure
- Package `arb_pkg` holds:
  - `arb_mode_e` (`ARB_FIXED`, `ARB_RR`)
  - `arb_state_e` (`IDLE`, `BUSY`)
  - helper function `onehot_to_idx`.
- Sub-module `prio_pick`: combinational masked priority picker.
  - Inputs: `req`, `mask`, `ptr`.
  - Outputs: one-hot winner and `any`.
  - Implementation: double-width rotate-and-priority.
- The top holds the FSM, grant register, pointer and hold counter.

## Test plan
- Reset then idle: `rst_n` low 3 cycles with `req`=4'b1111 → `gnt`=0 during reset.
  - After release, `gnt`=4'b0001 and `gnt_idx`=0 one cycle later.
- Fixed priority with `req`=4'b1010 → `gnt`=4'b0010.
  - Drop `req[1]` → next cycle `gnt`=4'b1000.
  - Drop all → `gnt`=0 and `gnt_valid`=0.
- RR rotation (`MODE`=`ARB_RR`), `req`=4'b1111, owner drops after 1 cycle each → grants 0,1,2,3,0 on consecutive cycles.
- Timeout (`MAX_HOLD`=4), `req`=4'b0011 held → `gnt`=0001 for 4 cycles, then `timeout` pulses with `gnt`=0010.
  - With only `req`=4'b0001 held → no pulse and the grant persists.
- Mid-grant reset: RR owner=2, assert `rst_n` low for 1 cycle → outputs 0 asynchronously.
  - With `req`=4'b1100 after release → `gnt`=4'b0100, showing the pointer restarted at 0.
- Simultaneous drop and timeout at the threshold cycle → new grant issued, `timeout`=0.
